// File: rtl/mux_host.sv
// Host-side sequencer for a UART-attached output mux: sends a command,
// streams payload bytes, collects the little-endian readback and reports.
module mux_host #(
  parameter int CLOCK_PER_BIT = 16,
  parameter int OUTPUT_COUNT  = 16,
  parameter int INPUT_COUNT   = 4,
  parameter int TIMEOUT       = 20 * CLOCK_PER_BIT * 10,
  localparam int SEL_W =
    $clog2(INPUT_COUNT) * OUTPUT_COUNT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [2:0]              req_cmd,
  input  logic [OUTPUT_COUNT-1:0] req_mask,
  input  logic [SEL_W-1:0]        req_map,
  output logic [7:0]              tx_data,
  output logic                    tx_data_ready,
  input  logic                    tx_done,
  input  logic                    rx_ready,
  input  logic [7:0]              rx_data,
  output logic                    rsp_valid,
  output logic [OUTPUT_COUNT-1:0] rsp_mask,
  output logic [SEL_W-1:0]        rsp_map,
  output logic [1:0]              rsp_err,
  output logic                    busy
);

  localparam int EN_BYTES  = OUTPUT_COUNT / 8;
  localparam int MAP_BYTES = SEL_W / 8;
  localparam int PAY_W =
    (OUTPUT_COUNT > SEL_W) ? OUTPUT_COUNT : SEL_W;
  localparam int PAY_BYTES = PAY_W / 8;
  localparam int MAX_IDX =
    (EN_BYTES > MAP_BYTES + 1) ? EN_BYTES : MAP_BYTES + 1;
  localparam int IDX_W = $clog2(MAX_IDX + 1);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_TX,
    S_RECV,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [2:0]              cmd_q, cmd_d;
  logic [OUTPUT_COUNT-1:0] mask_q, mask_d;
  logic [SEL_W-1:0]        map_q, map_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [TMR_W-1:0]        tmr_q, tmr_d;
  logic [1:0]              guard_q, guard_d;
  logic [PAY_W-1:0]        shadow_q, shadow_d;
  logic [1:0]              err_q, err_d;
  logic                    full_q, full_d;
  logic [7:0]              tx_data_q, tx_data_d;
  logic                    tx_pulse_q, tx_pulse_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [OUTPUT_COUNT-1:0] rsp_mask_q, rsp_mask_d;
  logic [SEL_W-1:0]        rsp_map_q, rsp_map_d;
  logic [1:0]              rsp_err_q, rsp_err_d;

  logic             cmd_ok;
  logic             mask_cmd;
  logic [IDX_W-1:0] tx_len;
  logic [IDX_W-1:0] rx_len;
  logic [PAY_W-1:0] pay_v;
  logic [7:0]       tx_byte;
  logic             mismatch;

  always_comb begin
    cmd_ok   = (req_cmd != 3'd0) && (req_cmd <= 3'd4);
    mask_cmd = (cmd_q == 3'd1) || (cmd_q == 3'd3);
    tx_len   = IDX_W'(1);
    unique case (1'b1)
      (cmd_q == 3'd3): tx_len = IDX_W'(EN_BYTES + 1);
      (cmd_q == 3'd4): tx_len = IDX_W'(MAP_BYTES + 1);
      default:         tx_len = IDX_W'(1);
    endcase
    rx_len = mask_cmd ? IDX_W'(EN_BYTES)
                      : IDX_W'(MAP_BYTES);
    pay_v  = (cmd_q == 3'd3) ? PAY_W'(mask_q)
                             : PAY_W'(map_q);
  end

  // byte 0 is the command, payload byte k goes out at index k+1
  always_comb begin
    tx_byte = {5'b0, cmd_q};
    for (int i = 0; i < PAY_BYTES; i++) begin
      if (int'(idx_q) == i + 1) begin
        tx_byte = pay_v[8*i +: 8];
      end
    end
  end

  always_comb begin
    mismatch = 1'b0;
    if (cmd_q == 3'd3) begin
      mismatch = shadow_q[OUTPUT_COUNT-1:0] != mask_q;
    end else if (cmd_q == 3'd4) begin
      mismatch = shadow_q[SEL_W-1:0] != map_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    mask_d      = mask_q;
    map_d       = map_q;
    idx_d       = idx_q;
    tmr_d       = tmr_q;
    guard_d     = guard_q;
    shadow_d    = shadow_q;
    err_d       = err_q;
    full_d      = full_q;
    tx_data_d   = tx_data_q;
    tx_pulse_d  = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_mask_d  = rsp_mask_q;
    rsp_map_d   = rsp_map_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          cmd_d  = req_cmd;
          mask_d = req_mask;
          map_d  = req_map;
          idx_d  = '0;
          full_d = 1'b0;
          err_d  = 2'b00;
          if (cmd_ok) begin
            state_d = S_SEND;
          end else begin
            err_d   = 2'b11;
            state_d = S_DONE;
          end
        end
      end
      S_SEND: begin
        if (tx_done) begin
          tx_data_d  = tx_byte;
          tx_pulse_d = 1'b1;
          guard_d    = 2'd2;
          state_d    = S_WAIT_TX;
        end
      end
      S_WAIT_TX: begin
        // uart_tx needs a couple of cycles to drop its idle flag
        if (guard_q != 2'd0) begin
          guard_d = guard_q - 2'd1;
        end else if (tx_done) begin
          if (idx_q + 1'b1 < tx_len) begin
            idx_d   = idx_q + 1'b1;
            state_d = S_SEND;
          end else begin
            idx_d   = '0;
            tmr_d   = '0;
            state_d = S_RECV;
          end
        end
      end
      S_RECV: begin
        if (rx_ready) begin
          for (int i = 0; i < PAY_BYTES; i++) begin
            if (int'(idx_q) == i) begin
              shadow_d[8*i +: 8] = rx_data;
            end
          end
          idx_d = idx_q + 1'b1;
          tmr_d = '0;
          if (idx_q + 1'b1 == rx_len) begin
            full_d  = 1'b1;
            state_d = S_DONE;
          end
        end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
          err_d   = 2'b01;
          state_d = S_DONE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_DONE: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = err_q;
        if (full_q) begin
          if (mask_cmd) begin
            rsp_mask_d = shadow_q[OUTPUT_COUNT-1:0];
          end else begin
            rsp_map_d = shadow_q[SEL_W-1:0];
          end
          rsp_err_d = mismatch ? 2'b10 : 2'b00;
        end
        idx_d   = '0;
        tmr_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cmd_q       <= 3'd0;
      mask_q      <= '0;
      map_q       <= '0;
      idx_q       <= '0;
      tmr_q       <= '0;
      guard_q     <= 2'd0;
      shadow_q    <= '0;
      err_q       <= 2'b00;
      full_q      <= 1'b0;
      tx_data_q   <= 8'hFF;
      tx_pulse_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_mask_q  <= '0;
      rsp_map_q   <= '0;
      rsp_err_q   <= 2'b00;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      mask_q      <= mask_d;
      map_q       <= map_d;
      idx_q       <= idx_d;
      tmr_q       <= tmr_d;
      guard_q     <= guard_d;
      shadow_q    <= shadow_d;
      err_q       <= err_d;
      full_q      <= full_d;
      tx_data_q   <= tx_data_d;
      tx_pulse_q  <= tx_pulse_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_mask_q  <= rsp_mask_d;
      rsp_map_q   <= rsp_map_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready     = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign tx_data       = tx_data_q;
  assign tx_data_ready = tx_pulse_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_mask      = rsp_mask_q;
  assign rsp_map       = rsp_map_q;
  assign rsp_err       = rsp_err_q;

endmodule

// File: tb/tb_mux_host.sv
// Scoreboard bench for mux_host: queued tx bytes and responses,
// a small uart_tx model and a scripted byte responder.
module tb_mux_host;

  localparam int TO = 20 * 16 * 10;

  typedef struct {
    logic [15:0] m;
    logic [31:0] p;
    logic [1:0]  e;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_cmd = 3'd0;
  logic [15:0] req_mask = '0;
  logic [31:0] req_map = '0;
  logic [7:0]  tx_data;
  logic        tx_data_ready;
  logic        tx_done;
  logic        rx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rsp_valid;
  logic [15:0] rsp_mask;
  logic [31:0] rsp_map;
  logic [1:0]  rsp_err;
  logic        busy;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int rsp_cnt = 0;
  int rsp_cyc = 0;
  int acc_cyc = 0;
  int rx_cyc = 0;
  int tx_cnt = 0;

  logic [7:0] exp_tx[$];
  rsp_t       exp_rsp[$];

  mux_host dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_mask(req_mask),
    .req_map(req_map),
    .tx_data(tx_data), .tx_data_ready(tx_data_ready),
    .tx_done(tx_done),
    .rx_ready(rx_ready), .rx_data(rx_data),
    .rsp_valid(rsp_valid), .rsp_mask(rsp_mask),
    .rsp_map(rsp_map), .rsp_err(rsp_err),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // uart_tx model: busy for a few cycles after each start pulse
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_done <= 1'b1;
      tx_cnt  <= 0;
    end else if (tx_data_ready) begin
      tx_done <= 1'b0;
      tx_cnt  <= 6;
    end else if (tx_cnt != 0) begin
      tx_cnt <= tx_cnt - 1;
      if (tx_cnt == 1) tx_done <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst_n && tx_data_ready) begin
      if (exp_tx.size() == 0) begin
        chk("tx_extra", {24'd0, tx_data}, 32'hxx);
      end else begin
        chk("tx_byte", {24'd0, tx_data},
            {24'd0, exp_tx.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    rsp_t e;
    if (rst_n && rsp_valid) begin
      rsp_cnt++;
      rsp_cyc = cyc;
      if (exp_rsp.size() == 0) begin
        chk("rsp_extra", 32'd1, 32'd0);
      end else begin
        e = exp_rsp.pop_front();
        chk("rsp_mask", {16'd0, rsp_mask}, {16'd0, e.m});
        chk("rsp_map", rsp_map, e.p);
        chk("rsp_err", {30'd0, rsp_err}, {30'd0, e.e});
        chk("busy_at_rsp", {31'd0, busy}, 32'd0);
      end
    end
  end

  task automatic push_rsp(input logic [15:0] m,
                          input logic [31:0] p,
                          input logic [1:0] e);
    rsp_t r;
    r.m = m; r.p = p; r.e = e;
    exp_rsp.push_back(r);
  endtask

  task automatic issue(input logic [2:0] c,
                       input logic [15:0] m,
                       input logic [31:0] p);
    @(negedge clk);
    chk("req_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_cmd   = c;
    req_mask  = m;
    req_map   = p;
    acc_cyc   = cyc;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain_tx();
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (exp_tx.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("tx_drain", {31'd0, ok}, 32'd1);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 50 && !tx_done; i++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    rx_ready = 1'b1;
    rx_data  = b;
    rx_cyc   = cyc;
    @(negedge clk);
    rx_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_rsp(input int n0, input int lim);
    bit ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (rsp_cnt > n0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("rsp_wait", {31'd0, ok}, 32'd1);
  endtask

  initial begin
    int n0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_txd", {24'd0, tx_data}, 32'h0000_00FF);
    chk("rst_txr", {31'd0, tx_data_ready}, 32'd0);
    chk("rst_mask", {16'd0, rsp_mask}, 32'd0);
    chk("rst_map", rsp_map, 32'd0);
    chk("rst_err", {30'd0, rsp_err}, 32'd0);
    rst_n = 1'b1;

    // cmd 1 read mask, with a stray rx byte during SEND
    exp_tx.push_back(8'h01);
    push_rsp(16'h1234, 32'h0, 2'b00);
    n0 = rsp_cnt;
    issue(3'd1, 16'hAAAA, 32'h0);
    rx_ready = 1'b1; rx_data = 8'h99;
    @(negedge clk);
    rx_ready = 1'b0;
    drain_tx();
    send_rx(8'h34);
    send_rx(8'h12);
    wait_rsp(n0, 50);

    // cmd 4 write map, with a request attempted while busy
    exp_tx = {8'h04, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    push_rsp(16'h1234, 32'hDEADBEEF, 2'b00);
    n0 = rsp_cnt;
    issue(3'd4, 16'h0, 32'hDEADBEEF);
    req_valid = 1'b1; req_cmd = 3'd1;
    @(negedge clk);
    chk("ready_busy", {31'd0, req_ready}, 32'd0);
    chk("busy_hi", {31'd0, busy}, 32'd1);
    repeat (2) @(negedge clk);
    req_valid = 1'b0;
    drain_tx();
    send_rx(8'hEF);
    send_rx(8'hBE);
    send_rx(8'hAD);
    send_rx(8'hDE);
    wait_rsp(n0, 50);

    // cmd 3 write mask with mismatching readback
    exp_tx = {8'h03, 8'hFF, 8'h00};
    push_rsp(16'h01FF, 32'hDEADBEEF, 2'b10);
    n0 = rsp_cnt;
    issue(3'd3, 16'h00FF, 32'h0);
    drain_tx();
    send_rx(8'hFF);
    send_rx(8'h01);
    wait_rsp(n0, 50);

    // cmd 2 with a short response times out
    exp_tx.push_back(8'h02);
    push_rsp(16'h01FF, 32'hDEADBEEF, 2'b01);
    n0 = rsp_cnt;
    issue(3'd2, 16'h0, 32'h0);
    drain_tx();
    send_rx(8'h11);
    send_rx(8'h22);
    wait_rsp(n0, TO + 100);
    chk("to_lat", rsp_cyc - rx_cyc, TO + 2);
    @(negedge clk);
    chk("to_busy", {31'd0, busy}, 32'd0);

    // invalid commands: no tx, response two cycles on
    push_rsp(16'h01FF, 32'hDEADBEEF, 2'b11);
    n0 = rsp_cnt;
    issue(3'd6, 16'h0, 32'h0);
    wait_rsp(n0, 10);
    chk("inv6_lat", rsp_cyc - acc_cyc, 32'd2);
    push_rsp(16'h01FF, 32'hDEADBEEF, 2'b11);
    n0 = rsp_cnt;
    issue(3'd0, 16'h0, 32'h0);
    wait_rsp(n0, 10);
    chk("inv0_lat", rsp_cyc - acc_cyc, 32'd2);

    // reset in WAIT_TX of cmd 4 abandons it
    exp_tx.push_back(8'h04);
    n0 = rsp_cnt;
    issue(3'd4, 16'h0, 32'h12345678);
    for (int i = 0; i < 20 && exp_tx.size() != 0; i++)
      @(negedge clk);
    chk("rst_tx_seen", exp_tx.size(), 32'd0);
    @(negedge clk);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_txd", {24'd0, tx_data}, 32'h0000_00FF);
    chk("arst_map", rsp_map, 32'd0);
    chk("arst_mask", {16'd0, rsp_mask}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("no_rsp_rst", rsp_cnt, n0);

    // fresh cmd 1 completes normally after reset
    exp_tx.push_back(8'h01);
    push_rsp(16'h55AA, 32'h0, 2'b00);
    n0 = rsp_cnt;
    issue(3'd1, 16'h0, 32'h0);
    drain_tx();
    send_rx(8'hAA);
    send_rx(8'h55);
    wait_rsp(n0, 50);

    repeat (5) @(negedge clk);
    chk("tx_left", exp_tx.size(), 32'd0);
    chk("rsp_left", exp_rsp.size(), 32'd0);
    chk("rsp_total", rsp_cnt, 32'd7);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_host.md
MUX_HOST -- requirements
Module: mux_host

Interface
REQ-001 Parameter CLOCK_PER_BIT, 16, UART bit period in clk cycles; sets the timeout default only.
REQ-002 Parameter OUTPUT_COUNT, 16, mux outputs; multiple of 8; EN_BYTES = OUTPUT_COUNT/8.
REQ-003 Parameter INPUT_COUNT, 4, mux inputs; SEL_W = $clog2(INPUT_COUNT)*OUTPUT_COUNT; multiple of 8; MAP_BYTES = SEL_W/8.
REQ-004 Parameter TIMEOUT, 20*CLOCK_PER_BIT*10, max clk cycles waited for each response byte.
REQ-005 Ports: one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  sole clock, all logic on posedge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 req_valid  in  1  host request present.
REQ-009 req_ready  out  1  high only in IDLE; request accepted on req_valid&req_ready.
REQ-010 req_cmd  in  3  1=read mask, 2=read map, 3=write mask, 4=write map; others invalid.
REQ-011 req_mask  in  OUTPUT_COUNT  enable mask payload for cmd 3.
REQ-012 req_map  in  SEL_W  pin map payload for cmd 4.
REQ-013 tx_data  out  8  byte to uart_tx, held stable from start pulse to byte completion.
REQ-014 tx_data_ready  out  1  one-cycle start pulse to uart_tx.
REQ-015 tx_done  in  1  uart_tx idle flag (high = idle).
REQ-016 rx_ready  in  1  one-cycle strobe, rx_data valid, synchronous to clk.
REQ-017 rx_data  in  8  received byte.
REQ-018 rsp_valid  out  1  one-cycle pulse, transaction finished.
REQ-019 rsp_mask  out  OUTPUT_COUNT  readback mask (cmd 1/3), else unchanged.
REQ-020 rsp_map  out  SEL_W  readback map (cmd 2/4), else unchanged.
REQ-021 rsp_err  out  2  00 ok, 01 timeout, 10 readback mismatch, 11 invalid cmd; valid with rsp_valid.
REQ-022 busy  out  1  high whenever state != IDLE.

Function
REQ-023 States: IDLE, SEND, WAIT_TX, RECV, DONE; one-hot or binary, implementation choice.
REQ-024 IDLE: on accept, latch cmd/mask/map; valid cmd -> SEND with byte index 0; invalid cmd -> DONE with rsp_err=11, nothing transmitted.
REQ-025 Transmit sequence: command byte {5'b0,cmd}, then for cmd 3 EN_BYTES of req_mask, for cmd 4 MAP_BYTES of req_map, little-endian (byte k = bits [8k+7:8k]).
REQ-026 SEND: when tx_done=1, drive tx_data and pulse tx_data_ready one cycle, go WAIT_TX.
REQ-027 WAIT_TX: ignore tx_done for 2 cycles after the pulse, then on tx_done=1 advance: more bytes -> SEND, else -> RECV with byte index and timeout counter cleared.
REQ-028 Expected response length: EN_BYTES for cmd 1/3, MAP_BYTES for cmd 2/4, little-endian assembly into a shadow register.
REQ-029 RECV: each rx_ready stores rx_data at current index, increments index, clears timeout counter; last byte -> DONE.
REQ-030 RECV: timeout counter increments every cycle without rx_ready; reaching TIMEOUT -> DONE with rsp_err=01; partial data not copied to rsp_mask/rsp_map.
REQ-031 DONE: complete response copies shadow into rsp_mask (cmd 1/3) or rsp_map (cmd 2/4); cmd 3/4 readback != latched payload -> rsp_err=10, else 00; pulse rsp_valid one cycle, return to IDLE.
REQ-032 rx_ready outside RECV (IDLE, SEND, WAIT_TX, DONE) is discarded with no state change.
REQ-033 req_valid while busy is ignored; req_ready=0; no queueing.
REQ-034 Byte index and counters sized to hold max(EN_BYTES, MAP_BYTES+1) and TIMEOUT without wrap.

Reset
REQ-035 rst_n low asynchronously forces IDLE; tx_data_ready=0, tx_data=8'hFF, rsp_valid=0, rsp_err=00, rsp_mask=0, rsp_map=0, busy=0, counters 0.
REQ-036 Reset mid-transaction abandons it with no rsp_valid; first request after release starts from command byte.
REQ-037 Release of rst_n takes effect on the next clk edge; req_ready=1 in the first cycle after release.

Verification
REQ-038 cmd 1, responder returns 8'h34, 8'h12 -> tx bytes 01; rsp_mask=16'h1234, rsp_err=00, one rsp_valid.
REQ-039 cmd 4, req_map=32'hDEADBEEF, echo EF BE AD DE -> tx 04 EF BE AD DE; rsp_map=32'hDEADBEEF, rsp_err=00.
REQ-040 cmd 3, req_mask=16'h00FF, responder returns FF 01 -> rsp_mask=16'h01FF, rsp_err=10.
REQ-041 cmd 2, only 2 of 4 bytes returned -> after TIMEOUT idle cycles rsp_err=01, rsp_map unchanged, busy drops.
REQ-042 cmd 6 -> no tx_data_ready pulse, rsp_valid next-but-one cycle with rsp_err=11.
REQ-043 rst_n low during WAIT_TX of cmd 4 -> immediate IDLE, no rsp_valid; new cmd 1 then completes normally.
